// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient loader and the fir_n filter.
package fir_pkg;

   localparam int unsigned FIR_N      = 32;
   localparam int unsigned FIR_DELAYS = 3;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMMIT
   } loader_state_t;

   function automatic int unsigned idx_w(input int unsigned delays);
      return $clog2(delays + 1);
   endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Word-at-a-time coefficient write stream (valid/ready).
interface fir_coeff_loader_if #(
   parameter int unsigned N = 32
);
   logic [N-1:0] wr_data;
   logic         wr_valid;
   logic         wr_ready;

   modport master (output wr_data, output wr_valid, input  wr_ready);
   modport slave  (input  wr_data, input  wr_valid, output wr_ready);
endinterface

// File: rtl/fir_coeff_bank.sv
// Shadow coefficient array plus the active packed bus, copied across in one edge.
module fir_coeff_bank
   import fir_pkg::*;
#(
   parameter  int unsigned N      = FIR_N,
   parameter  int unsigned DELAYS = FIR_DELAYS,
   localparam int unsigned IDX_W  = idx_w(DELAYS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic                     commit,
   input  logic [IDX_W-1:0]         idx,
   input  logic [N-1:0]             data,
   output logic [(DELAYS+1)*N-1:0]  b
);

   localparam int unsigned TAPS = DELAYS + 1;

   logic [N-1:0] shadow [TAPS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < TAPS; i++) shadow[i] <= '0;
         b <= '0;
      end else begin
         for (int unsigned i = 0; i < TAPS; i++) begin
            if (we && (idx == IDX_W'(i))) shadow[i] <= data;
         end
         if (commit) begin
            for (int unsigned i = 0; i < TAPS; i++) b[i*N +: N] <= shadow[i];
         end
      end
   end

endmodule

// File: rtl/fir_coeff_loader.sv
// Collects DELAYS+1 coefficient words into a shadow bank and commits them atomically to b.
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter  int unsigned DELAYS = FIR_DELAYS,
   parameter  int unsigned N      = FIR_N,
   localparam int unsigned IDX_W  = idx_w(DELAYS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic                     start,
   input  logic                     abort,
   fir_coeff_loader_if.slave        wr,
   output logic [(DELAYS+1)*N-1:0]  b,
   output logic [IDX_W-1:0]         load_idx,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DELAYS);

   loader_state_t    state, state_next;
   logic [IDX_W-1:0] idx_next;
   logic             err_next;
   logic             done_next;
   logic             shadow_we;
   logic             commit;

   assign wr.wr_ready = ena && (state == LOAD);
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         load_idx <= '0;
         err      <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         load_idx <= idx_next;
         err      <= err_next;
         done     <= done_next;
      end
   end

   // abort outranks start, which outranks the handshake; both drop a coincident word
   always_comb begin
      state_next = state;
      idx_next   = load_idx;
      err_next   = err;
      done_next  = 1'b0;
      shadow_we  = 1'b0;
      commit     = 1'b0;
      if (ena) begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_next = LOAD;
                  idx_next   = '0;
                  err_next   = 1'b0;
               end else if (wr.wr_valid) begin
                  err_next = 1'b1;
               end
            end
            LOAD: begin
               if (abort) begin
                  state_next = IDLE;
                  idx_next   = '0;
               end else if (start) begin
                  idx_next = '0;
                  err_next = 1'b1;
               end else if (wr.wr_valid) begin
                  shadow_we = 1'b1;
                  if (load_idx == LAST_IDX) state_next = COMMIT;
                  else                      idx_next   = load_idx + 1'b1;
               end
            end
            COMMIT: begin
               commit     = 1'b1;
               done_next  = 1'b1;
               idx_next   = '0;
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
               idx_next   = '0;
            end
         endcase
      end
   end

   fir_coeff_bank #(
      .N      (N),
      .DELAYS (DELAYS)
   ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (shadow_we),
      .commit (commit),
      .idx    (load_idx),
      .data   (wr.wr_data),
      .b      (b)
   );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader with a word-queue reference model checked every cycle.
module tb_fir_coeff_loader;

   localparam int unsigned DELAYS = 3;
   localparam int unsigned N      = 32;
   localparam int unsigned TAPS   = DELAYS + 1;
   localparam int unsigned W      = TAPS * N;
   localparam int unsigned IDX_W  = $clog2(DELAYS + 1);

   logic             clk   = 1'b0;
   logic             rst   = 1'b1;
   logic             ena   = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [W-1:0]     b;
   logic [IDX_W-1:0] load_idx;
   logic             busy, done, err;

   int unsigned passed = 0;
   int unsigned total  = 0;

   fir_coeff_loader_if #(.N(N)) wr_if ();

   fir_coeff_loader #(
      .DELAYS (DELAYS),
      .N      (N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .start    (start),
      .abort    (abort),
      .wr       (wr_if.slave),
      .b        (b),
      .load_idx (load_idx),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      else passed++;
   endtask

   // Reference model: a loading flag plus the queue of words accepted since the last start
   logic [N-1:0] m_b [TAPS];
   logic [N-1:0] pend [$];
   bit           m_loading = 1'b0;
   bit           m_err     = 1'b0;
   bit           m_done    = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) m_b[i] = '0;
         pend.delete();
         m_loading = 1'b0;
         m_err     = 1'b0;
         m_done    = 1'b0;
      end else begin
         m_done = 1'b0;
         if (ena) begin
            if (pend.size() == TAPS) begin
               for (int i = 0; i < TAPS; i++) m_b[i] = pend[i];
               pend.delete();
               m_loading = 1'b0;
               m_done    = 1'b1;
            end else if (!m_loading) begin
               if (start) begin
                  m_loading = 1'b1;
                  pend.delete();
                  m_err = 1'b0;
               end else if (wr_if.wr_valid) begin
                  m_err = 1'b1;
               end
            end else if (abort) begin
               m_loading = 1'b0;
               pend.delete();
            end else if (start) begin
               pend.delete();
               m_err = 1'b1;
            end else if (wr_if.wr_valid) begin
               pend.push_back(wr_if.wr_data);
            end
         end
      end
   end

   function automatic logic [W-1:0] model_b();
      logic [W-1:0] v;
      for (int i = 0; i < TAPS; i++) v[i*N +: N] = m_b[i];
      return v;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         check("b",        b,                model_b());
         check("load_idx", W'(load_idx),     W'((pend.size() == TAPS) ? DELAYS : pend.size()));
         check("busy",     W'(busy),         W'(m_loading));
         check("done",     W'(done),         W'(m_done));
         check("err",      W'(err),          W'(m_err));
         check("wr_ready", W'(wr_if.wr_ready), W'(ena && m_loading && (pend.size() < TAPS)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [N-1:0] w);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = w;
      tick();
      wr_if.wr_valid = 1'b0;
   endtask

   logic [W-1:0] set_a, set_9, set_r, set_e, set_g;
   logic [N-1:0] gap_vals [4];

   initial begin
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = '0;
      set_a = {32'd4, 32'd3, 32'd2, 32'd1};
      set_9 = {32'd9, 32'd9, 32'd9, 32'd9};
      set_r = {32'd8, 32'd7, 32'd6, 32'd5};
      set_e = {32'd6, 32'd5, 32'd4, 32'd3};
      set_g = {32'd11, 32'hFFFF_FFF7, 32'd7, 32'hFFFF_FFFB};
      gap_vals[0] = -32'sd5;
      gap_vals[1] = 32'sd7;
      gap_vals[2] = -32'sd9;
      gap_vals[3] = 32'sd11;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_b",    b, '0);
      check("reset_busy", W'(busy), '0);
      check("reset_err",  W'(err), '0);

      // basic load 1,2,3,4
      pulse_start();
      check("ready_in_load", W'(wr_if.wr_ready), W'(1));
      for (int k = 1; k <= 4; k++) send(N'(k));
      check("b_before_commit", b, '0);
      check("done_before_commit", W'(done), '0);
      tick();
      check("done_at_commit", W'(done), W'(1));
      check("b_set_a", b, set_a);
      check("model_set_a", model_b(), set_a);
      tick();
      check("done_one_cycle", W'(done), '0);

      // abort after two words keeps the prior set
      pulse_start();
      send(32'd5);
      send(32'd6);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_b", b, set_a);
      check("abort_busy", W'(busy), '0);
      check("abort_err", W'(err), '0);
      pulse_start();
      for (int k = 0; k < 4; k++) send(32'd9);
      tick();
      check("b_set_9", b, set_9);

      // restart inside LOAD drops the coincident word and flags err
      pulse_start();
      send(32'd1);
      send(32'd2);
      check("idx_two", W'(load_idx), W'(2));
      start = 1'b1;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 32'd77;
      tick();
      start = 1'b0;
      wr_if.wr_valid = 1'b0;
      check("restart_err", W'(err), W'(1));
      check("restart_idx", W'(load_idx), '0);
      for (int k = 5; k <= 8; k++) send(N'(k));
      tick();
      check("b_restart", b, set_r);
      check("err_sticky", W'(err), W'(1));
      pulse_start();
      check("err_cleared", W'(err), '0);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // ena low for five cycles after one word
      pulse_start();
      send(32'd3);
      ena = 1'b0;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 32'd99;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("ena_ready", W'(wr_if.wr_ready), '0);
         check("ena_idx", W'(load_idx), W'(1));
         check("ena_done", W'(done), '0);
      end
      wr_if.wr_valid = 1'b0;
      ena = 1'b1;
      for (int k = 4; k <= 6; k++) send(N'(k));
      tick();
      check("b_ena", b, set_e);

      // gaps between words: index advances only on accepts
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         send(gap_vals[k]);
         if (k < 3) check("gap_idx_acc", W'(load_idx), W'(k + 1));
         tick();
         if (k < 3) check("gap_idx_hold", W'(load_idx), W'(k + 1));
      end
      check("b_gaps", b, set_g);
      check("gaps_done", W'(done), W'(1));

      // stray write in IDLE
      send(32'd123);
      check("stray_err", W'(err), W'(1));

      // async reset between edges mid-load
      pulse_start();
      send(32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_b", b, '0);
      check("arst_busy", W'(busy), '0);
      check("arst_ready", W'(wr_if.wr_ready), '0);
      check("arst_idx", W'(load_idx), '0);
      rst = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
